btn_updown_counter: RTL

BTN_UPDOWN_COUNTER -- requirements
Module: btn_updown_counter

---
 rtl/p1_pkg.sv | 17 +
 rtl/btn_updown_counter_if.sv | 30 +++
 rtl/btn_debounce.sv | 99 +++++++++
 rtl/btn_updown_counter.sv | 81 ++++++++
 4 files changed

// File: rtl/p1_pkg.sv
// Shared definitions for the button up/down counter.
//   NUM_W       - width of the displayed count
//   NUM_MAX     - largest count value
//   deb_state_e - per-button debounce FSM states
package p1_pkg;

    localparam int unsigned        NUM_W   = 4;
    localparam logic [NUM_W-1:0]   NUM_MAX = 4'd15;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CHK_P   = 2'd1,
        PRESSED = 2'd2,
        CHK_R   = 2'd3
    } deb_state_e;

endpackage

// File: rtl/btn_updown_counter_if.sv
// Signal bundle between the counter and its environment.
//   btn_up_n / btn_dn_n : raw active-low pushbuttons (into the counter)
//   clr                 : synchronous clear (into the counter)
//   num                 : registered count 0..15
//   up_pulse / dn_pulse : one-clock strobes per accepted press
//   at_max / at_min     : registered flags for num==15 / num==0
// master drives the buttons and clear; slave is the counter itself.
interface btn_updown_counter_if;
    import p1_pkg::*;

    logic             btn_up_n;
    logic             btn_dn_n;
    logic             clr;
    logic [NUM_W-1:0] num;
    logic             up_pulse;
    logic             dn_pulse;
    logic             at_max;
    logic             at_min;

    modport master (
        output btn_up_n, btn_dn_n, clr,
        input  num, up_pulse, dn_pulse, at_max, at_min
    );

    modport slave (
        input  btn_up_n, btn_dn_n, clr,
        output num, up_pulse, dn_pulse, at_max, at_min
    );

endinterface

// File: rtl/btn_debounce.sv
// Debouncer for one raw active-low pushbutton: 2-flop synchronizer, debounce FSM
// with a stable-sample counter, and a one-clock pulse per accepted press.
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   btn_n  : raw, bouncing, active-low button
//   pulse  : one-clock strobe on the clock the FSM enters PRESSED
// DEB_CYCLES (>= 2) is the number of consecutive synced samples needed to accept
// a level change.
module btn_debounce
    import p1_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic pulse
);

    localparam int unsigned     CNT_W    = $clog2(DEB_CYCLES);
    // The sample taken when leaving IDLE/PRESSED counts as the first of the
    // DEB_CYCLES stable samples, so the counter tops out one short of DEB_CYCLES-1.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 2);

    logic             sync1_q, sync2_q;
    logic             pressed;
    deb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_q, pulse_d;

    // Synchronizer resets to the released level so reset release cannot look like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= btn_n;
            sync2_q <= sync1_q;
        end
    end

    assign pressed = ~sync2_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (pressed) begin
                    state_d = CHK_P;
                    cnt_d   = '0;
                end
            end
            CHK_P: begin
                if (!pressed) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PRESSED: begin
                if (!pressed) begin
                    state_d = CHK_R;
                    cnt_d   = '0;
                end
            end
            CHK_R: begin
                if (pressed) begin
                    state_d = PRESSED;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Only a fresh press pulses; bounce on release (CHK_R -> PRESSED) must not repeat.
    assign pulse_d = (state_q == CHK_P) && (state_d == PRESSED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/btn_updown_counter.sv
// 4-bit up/down counter driven by two debounced pushbuttons.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of btn_updown_counter_if (buttons, clr, num, pulses, flags)
// DEB_CYCLES sets the debounce acceptance length; WRAP selects wrap-around (1)
// or saturation (0) at the 0/15 limits.
module btn_updown_counter
    import p1_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 500000,
    parameter bit          WRAP       = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    btn_updown_counter_if.slave  bus
);

    logic             up_pulse, dn_pulse;
    logic [NUM_W-1:0] num_q, num_d;
    logic             at_max_q, at_min_q;

    btn_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_deb_up (
        .clk   (clk),
        .rst_n (rst_n),
        .btn_n (bus.btn_up_n),
        .pulse (up_pulse)
    );

    btn_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_deb_dn (
        .clk   (clk),
        .rst_n (rst_n),
        .btn_n (bus.btn_dn_n),
        .pulse (dn_pulse)
    );

    // Priority: clr, then simultaneous up+dn (no change), then up, then down.
    always_comb begin
        num_d = num_q;
        if (bus.clr) begin
            num_d = '0;
        end else if (up_pulse && dn_pulse) begin
            num_d = num_q;
        end else if (up_pulse) begin
            if (num_q == NUM_MAX) begin
                num_d = WRAP ? '0 : NUM_MAX;
            end else begin
                num_d = num_q + 1'b1;
            end
        end else if (dn_pulse) begin
            if (num_q == '0) begin
                num_d = WRAP ? NUM_MAX : '0;
            end else begin
                num_d = num_q - 1'b1;
            end
        end
    end

    // Flags are computed from num_d so they land on the same edge as num.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_q    <= '0;
            at_max_q <= 1'b0;
            at_min_q <= 1'b1;
        end else begin
            num_q    <= num_d;
            at_max_q <= (num_d == NUM_MAX);
            at_min_q <= (num_d == '0);
        end
    end

    assign bus.num      = num_q;
    assign bus.at_max   = at_max_q;
    assign bus.at_min   = at_min_q;
    assign bus.up_pulse = up_pulse;
    assign bus.dn_pulse = dn_pulse;

endmodule
